cnn_pool2x2_stream: RTL

Streaming 2x2 / stride-2 signed max-pool stage for the CNN accelerator datapath. It sits directly downstream of the ReLU stage and consumes that stage's raster-order feature-map stream over valid/ready. It emits one pooled value per 2x2 tile to the write-back path. A half-width row buffer replaces the combinational four-input pool, so the tile is built from the real stream and not from one replicated sample.

---
 rtl/cnn_pool_pkg.sv | 18 +
 rtl/cnn_pool_row_buf.sv | 28 ++
 rtl/cnn_pool2x2_stream.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cnn_pool_pkg.sv
// Shared types and default dimensions for the streaming 2x2 max-pool stage.
package cnn_pool_pkg;

    localparam int unsigned POOL_IMG_W = 26;
    localparam int unsigned POOL_IMG_H = 26;
    localparam int unsigned POOL_DW    = 32;

    typedef enum logic {
        ROW_EVEN = 1'b0,
        ROW_ODD  = 1'b1
    } pool_phase_t;

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/cnn_pool_row_buf.sv
// Half-width row buffer: holds the horizontal pair maxima of the even row.
module cnn_pool_row_buf
    import cnn_pool_pkg::*;
#(
    parameter int unsigned DEPTH      = POOL_IMG_W / 2,
    parameter int unsigned DATA_WIDTH = POOL_DW,
    parameter int unsigned ADDR_W     = clog2_min1(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Contents need no reset: every entry is written on the even row before the odd row reads it.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/cnn_pool2x2_stream.sv
// Streaming 2x2 / stride-2 signed max-pool over a raster-order valid/ready feature-map stream.
module cnn_pool2x2_stream
    import cnn_pool_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = POOL_DW,
    parameter int unsigned IMG_WIDTH  = POOL_IMG_W,
    parameter int unsigned IMG_HEIGHT = POOL_IMG_H
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  frame_done_o,
    output logic                  busy_o
);

    localparam int unsigned COL_W     = clog2_min1(IMG_WIDTH);
    localparam int unsigned ROW_W     = clog2_min1(IMG_HEIGHT);
    localparam int unsigned BUF_DEPTH = IMG_WIDTH / 2;
    localparam int unsigned ADDR_W    = clog2_min1(BUF_DEPTH);

    generate
        if (IMG_WIDTH < 2 || (IMG_WIDTH % 2) != 0) begin : g_bad_width
            $error("cnn_pool2x2_stream: IMG_WIDTH must be even and >= 2");
        end
        if (IMG_HEIGHT < 2 || (IMG_HEIGHT % 2) != 0) begin : g_bad_height
            $error("cnn_pool2x2_stream: IMG_HEIGHT must be even and >= 2");
        end
    endgenerate

    function automatic logic signed [DATA_WIDTH-1:0] smax(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    pool_phase_t                   phase_q, phase_d;
    logic [COL_W-1:0]              col_q, col_d;
    logic [ROW_W-1:0]              row_q, row_d;
    logic signed [DATA_WIDTH-1:0]  hmax_q, hmax_d;
    logic signed [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic                          out_valid_q, out_valid_d;
    logic                          last_q, last_d;

    logic signed [DATA_WIDTH-1:0]  in_data_s;
    logic signed [DATA_WIDTH-1:0]  pair_max;
    logic signed [DATA_WIDTH-1:0]  tile_max;
    logic [DATA_WIDTH-1:0]         buf_rd_data;
    logic [ADDR_W-1:0]             buf_addr;
    logic                          buf_we;
    logic                          col_last, row_last;
    logic                          producing_pos;
    logic                          in_beat, out_beat;

    assign in_data_s     = $signed(in_data_i);
    assign col_last      = (col_q == COL_W'(IMG_WIDTH - 1));
    assign row_last      = (row_q == ROW_W'(IMG_HEIGHT - 1));
    assign producing_pos = (phase_q == ROW_ODD) && col_q[0];
    assign buf_addr      = ADDR_W'(col_q >> 1);

    // Only the tile-completing position can be held off, and only while the output is stalled.
    assign in_ready_o = !(producing_pos && out_valid_q && !out_ready_i);
    assign in_beat    = in_valid_i && in_ready_o;
    assign out_beat   = out_valid_q && out_ready_i;

    assign pair_max = smax(hmax_q, in_data_s);
    assign tile_max = smax(pair_max, $signed(buf_rd_data));

    cnn_pool_row_buf #(
        .DEPTH      (BUF_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (ADDR_W)
    ) u_row_buf (
        .clk_i     (clk_i),
        .wr_en_i   (buf_we),
        .wr_addr_i (buf_addr),
        .wr_data_i (pair_max),
        .rd_addr_i (buf_addr),
        .rd_data_o (buf_rd_data)
    );

    // Next-state: raster counters, row phase, horizontal pair max and output register.
    always_comb begin
        phase_d     = phase_q;
        col_d       = col_q;
        row_d       = row_q;
        hmax_d      = hmax_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        buf_we      = 1'b0;

        if (clear_i) begin
            phase_d     = ROW_EVEN;
            col_d       = '0;
            row_d       = '0;
            hmax_d      = '0;
            out_data_d  = '0;
            out_valid_d = 1'b0;
            last_d      = 1'b0;
        end else begin
            if (out_beat) begin
                out_valid_d = 1'b0;
                last_d      = 1'b0;
            end
            if (in_beat) begin
                if (!col_q[0]) begin
                    hmax_d = in_data_s;
                end else if (phase_q == ROW_EVEN) begin
                    buf_we = 1'b1;
                end else begin
                    out_data_d  = tile_max;
                    out_valid_d = 1'b1;
                    last_d      = col_last && row_last;
                end

                if (col_last) begin
                    col_d   = '0;
                    row_d   = row_last ? '0 : row_q + ROW_W'(1);
                    phase_d = (phase_q == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q     <= ROW_EVEN;
            col_q       <= '0;
            row_q       <= '0;
            hmax_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            col_q       <= col_d;
            row_q       <= row_d;
            hmax_q      <= hmax_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
        end
    end

    assign out_data_o   = out_data_q;
    assign out_valid_o  = out_valid_q;
    assign frame_done_o = out_beat && last_q && !clear_i;
    assign busy_o       = (col_q != '0) || (row_q != '0) || out_valid_q;

endmodule
